// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master pipelined Wishbone arbiter; m1 (data) preempts m0 (ifetch) after draining in-flight acks.
module wb_mem_arbiter #(
  parameter int MAX_OUT = 15,
  localparam int CW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [31:0]   m0_adr,
  input  logic [31:0]   m0_dat_w,
  output logic [31:0]   m0_dat_r,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [31:0]   m1_adr,
  input  logic [31:0]   m1_dat_w,
  output logic [31:0]   m1_dat_r,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [3:0]    s_sel,
  output logic [31:0]   s_adr,
  output logic [31:0]   s_dat_w,
  input  logic [31:0]   s_dat_r,
  input  logic          s_ack,
  input  logic          s_stall,
  output logic [1:0]    grant,
  output logic [CW-1:0] outstanding
);
  typedef enum logic [1:0] {S_IDLE, S_M0, S_M1, S_DRAIN} state_t;
  state_t state;
  logic tgt_m1, from_m1, own0, own1, drain, full, accept, dec;
  logic [CW-1:0] cnt, cnt_nxt;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign grant = {own1, own0};
  assign outstanding = cnt;
  always_comb begin
    own0 = state == S_M0;
    own1 = state == S_M1;
    drain = state == S_DRAIN;
    full = cnt == CW'(MAX_OUT);
    s_cyc = own0 ? m0_cyc : own1 ? m1_cyc : drain;
    s_stb = own0 ? m0_stb & m0_cyc & !m1_cyc & !full : own1 & m1_stb & m1_cyc & !full;
    s_we = own0 ? m0_we : own1 & m1_we;
    s_sel = own0 ? m0_sel : own1 ? m1_sel : 4'h0;
    s_adr = own0 ? m0_adr : own1 ? m1_adr : 32'h0;
    s_dat_w = own0 ? m0_dat_w : own1 ? m1_dat_w : 32'h0;
    m0_stall = own0 ? s_stall | full | m1_cyc : 1'b1;
    m1_stall = own1 ? s_stall | full : 1'b1;
    // during drain, acks still belong to the master that issued them
    m0_ack = s_ack & m0_cyc & (own0 | (drain & !from_m1));
    m1_ack = s_ack & m1_cyc & (own1 | (drain & from_m1));
    accept = s_stb & !s_stall;
    dec = s_ack & (cnt != '0);
    cnt_nxt = cnt + CW'(accept) - CW'(dec);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      tgt_m1 <= 1'b0;
      from_m1 <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        S_IDLE: state <= m1_cyc ? S_M1 : m0_cyc ? S_M0 : S_IDLE;
        S_M0:
          if (m1_cyc || !m0_cyc) begin
            state <= (!m1_cyc && cnt == '0) ? S_IDLE : S_DRAIN;
            tgt_m1 <= m1_cyc;
            from_m1 <= 1'b0;
          end
        S_M1:
          if (!m1_cyc) begin
            state <= cnt != '0 ? S_DRAIN : m0_cyc ? S_M0 : S_IDLE;
            tgt_m1 <= 1'b0;
            from_m1 <= 1'b1;
          end
        S_DRAIN: if (cnt_nxt == '0) state <= tgt_m1 ? S_M1 : S_IDLE;
      endcase
    end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
Two-master, one-slave pipelined Wishbone arbiter that shares the single memory port between the instruction fetch unit (m0) and the data/memory stage (m1).
- Grants one owner at a time and muxes the owner's request onto the slave bus.
- Tracks outstanding pipelined requests so the grant never moves while acks are still in flight.
- Ifetch holds cyc continuously, so the data master can preempt it by draining ifetch's in-flight requests first.

Parameters:
MAX_OUT, 15, maximum outstanding (accepted, un-acked) slave requests; counter width is clog2(MAX_OUT+1).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m0_cyc, m0_stb, m0_we  in  1  ifetch master cycle/strobe/write
m0_sel  in  4  ifetch byte selects
m0_adr  in  32  ifetch address
m0_dat_w  in  32  ifetch write data
m0_dat_r  out  32  read data to ifetch (= s_dat_r)
m0_ack, m0_stall  out  1  ack/stall to ifetch
m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat_w, m1_dat_r, m1_ack, m1_stall  (same directions and widths as m0_*)  data master
s_cyc, s_stb, s_we  out  1  slave cycle/strobe/write
s_sel  out  4  slave byte selects
s_adr  out  32  slave address
s_dat_w  out  32  slave write data
s_dat_r  in  32  slave read data
s_ack, s_stall  in  1  slave ack/stall
grant  out  2  one-hot owner status: bit0 = m0, bit1 = m1
outstanding  out  clog2(MAX_OUT+1)  in-flight request count

Behaviour:
- States: S_IDLE, S_M0, S_M1, S_DRAIN. Registers: state, drain_target, outstanding count.
- Reset: state = S_IDLE, count = 0, grant = 0.
  - All s_* outputs 0.
  - m0_ack = m1_ack = 0; m0_stall = m1_stall = 1.
- Accept: accept = s_stb & !s_stall.
  - Count +1 on accept, -1 on s_ack; both in the same cycle leaves the count unchanged.
  - s_ack with count 0 is ignored; the count never underflows.
- Owner muxing (S_M0 / S_M1):
  - s_cyc = owner cyc.
  - s_stb = owner stb & owner cyc & (count < MAX_OUT).
  - s_adr, s_we, s_sel, s_dat_w = owner's signals.
  - owner stall = s_stall | (count == MAX_OUT).
  - owner ack = s_ack & owner cyc.
  - Non-owner: stall = 1, ack = 0.
- S_IDLE:
  - If m1_cyc, go to S_M1; else if m0_cyc, go to S_M0.
  - Grant takes 1 cycle: no stb is forwarded in the request cycle, and both stalls are held at 1.
- S_M0:
  - If m1_cyc, go to S_DRAIN with target M1 (preemption). In that cycle m0_stall = 1 and s_stb = 0.
  - Else if !m0_cyc: go to S_IDLE when count == 0, else S_DRAIN with target IDLE.
- S_M1:
  - m1 is never preempted.
  - When !m1_cyc: if count != 0, go to S_DRAIN with target IDLE; else go to S_M0 if m0_cyc, else S_IDLE.
- S_DRAIN:
  - s_cyc = 1, s_stb = 0; both stalls = 1.
  - Acks are forwarded to the former owner only while that owner's cyc is still high; otherwise they are absorbed. This covers ifetch dropping cyc on pc_set with fetches in flight.
  - When count reaches 0 (including the cycle in which the last ack decrements it to 0), go to the target: M1 → S_M1; IDLE → S_IDLE.
- Priority: m1 beats m0 on a simultaneous request; m0 is granted on m1 release. The data stage is expected to issue short bursts, so ifetch does not starve.
- s_dat_r is broadcast to both masters unconditionally.
- grant reflects the registered state; it is 0 in S_IDLE and S_DRAIN.
- Reset asserted mid-transfer returns to S_IDLE and clears the count immediately. Late slave acks after reset are ignored by the zero-count rule.

Test Plan:
- m0 alone, cyc held, slave never stalls, ack 1 cycle after stb → grant = 01 one cycle after cyc; m0 streams at 1 req/cycle; s_adr follows m0_adr; count stays ≤ 1.
- m0 and m1 raise cyc in the same cycle → grant = 10; m0_stall = 1 throughout; m1's read at 0x1000 returns on m1_ack only; m0_ack never asserted.
- m0 streaming with 3 in flight, then m1_cyc rises → S_DRAIN; s_stb = 0; exactly 3 m0_acks delivered; grant = 10 the cycle after count hits 0.
- Slave ack latency 20, MAX_OUT = 15 → 16th m0 request is stalled until the first ack; count never exceeds 15.
- m0 drops cyc with 2 requests in flight → both acks absorbed (m0_ack = 0); state goes to S_IDLE; a subsequent m0 request is granted cleanly.
- rst_i pulsed while m1 is owner with 2 outstanding → outputs return to reset values asynchronously; post-reset s_ack pulses leave count at 0.
